// File: rtl/cfu_resp_tracker.sv
// CFU request-ID tracker: credit-limited request passthrough plus a response buffer that re-pairs data with IDs.
// Optional watchdog enabled by defining CFU_RESP_TRACKER_TIMEOUT_EN.
module cfu_resp_tracker #(
    parameter int ID_W           = 4,
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         up_req_valid,
    output logic                         up_req_ready,
    input  logic [ID_W-1:0]              up_req_id,
    output logic                         dn_req_valid,
    input  logic                         dn_req_ready,
    input  logic                         dn_resp_valid,
    input  logic [DATA_W-1:0]            dn_resp_data,
    output logic                         up_resp_valid,
    input  logic                         up_resp_ready,
    output logic [ID_W-1:0]              up_resp_id,
    output logic [DATA_W-1:0]            up_resp_data,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic                         resp_err,
    output logic                         timeout_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [ID_W-1:0]   r_id_mem  [DEPTH];
    logic [DATA_W-1:0] r_dat_mem [DEPTH];

    logic [PW-1:0] r_id_wr;
    logic [PW-1:0] r_id_rd;
    logic [PW-1:0] r_dat_wr;
    logic [PW-1:0] r_dat_rd;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_pend;
    logic [CW-1:0] r_dcnt;
    logic          r_resp_err;

    logic w_not_full;
    logic w_accept;
    logic w_match;
    logic w_resp_vld;
    logic w_deliver;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Credit check uses registered state only, so no ready-to-ready path.
    assign w_not_full = (r_cnt < DEPTH_C);
    assign dn_req_valid = up_req_valid & w_not_full;
    assign up_req_ready = dn_req_ready & w_not_full;
    assign w_accept = up_req_valid & up_req_ready;

    assign w_match    = dn_resp_valid & (r_pend != '0);
    assign w_resp_vld = (r_dcnt != '0);
    assign w_deliver  = w_resp_vld & up_resp_ready;

    assign up_resp_valid = w_resp_vld;
    assign up_resp_id    = w_resp_vld ? r_id_mem[r_id_rd] : '0;
    assign up_resp_data  = w_resp_vld ? r_dat_mem[r_dat_rd] : '0;
    assign outstanding   = r_cnt;
    assign resp_err      = r_resp_err;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_id_mem[r_id_wr] <= up_req_id;
        end
        if (w_match) begin
            r_dat_mem[r_dat_wr] <= dn_resp_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_wr    <= '0;
            r_id_rd    <= '0;
            r_dat_wr   <= '0;
            r_dat_rd   <= '0;
            r_cnt      <= '0;
            r_pend     <= '0;
            r_dcnt     <= '0;
            r_resp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_id_wr <= f_inc(r_id_wr);
            end
            if (w_match) begin
                r_dat_wr <= f_inc(r_dat_wr);
            end
            if (w_deliver) begin
                r_id_rd  <= f_inc(r_id_rd);
                r_dat_rd <= f_inc(r_dat_rd);
            end
            r_cnt  <= r_cnt + CW'(w_accept) - CW'(w_deliver);
            r_pend <= r_pend + CW'(w_accept) - CW'(w_match);
            r_dcnt <= r_dcnt + CW'(w_match) - CW'(w_deliver);
            if (dn_resp_valid && (r_pend == '0)) begin
                r_resp_err <= 1'b1;
            end
        end
    end

`ifdef CFU_RESP_TRACKER_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] TMAX = WW'(TIMEOUT_CYCLES);

    logic [WW-1:0] r_wdog;
    logic [WW-1:0] w_wdog_nxt;
    logic          r_tout;

    always_comb begin
        w_wdog_nxt = r_wdog;
        if ((r_pend == '0) || w_match) begin
            w_wdog_nxt = '0;
        end else if (r_wdog != TMAX) begin
            w_wdog_nxt = r_wdog + WW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
            r_tout <= 1'b0;
        end else begin
            r_wdog <= w_wdog_nxt;
            if (w_wdog_nxt == TMAX) begin
                r_tout <= 1'b1;
            end
        end
    end

    assign timeout_err = r_tout;
`else
    // Watchdog not built; the expression is constant 0.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: doc/cfu_resp_tracker.md
Name: cfu_resp_tracker

Overview:
- Parametrised successor to the fixed-depth CFU request-ID FIFO used in accelerator wrappers.
- Sits between a CVA5 CFU slave port and an in-order accelerator core, for example a vector unit.
- Tracks request IDs and enforces a credit limit on outstanding requests.
- Buffers accelerator responses so the CPU side can apply backpressure, even though the accelerator cannot.
- Pairs each response with its original ID and flags protocol errors.

Parameters:
- ID_W, 4: width of the CFU request/response ID.
- DATA_W, 32: response data width.
- DEPTH, 4: maximum outstanding requests, counted as in flight plus buffered responses. Must be ≥ 1.
- TIMEOUT_CYCLES, 1024: watchdog limit. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- up_req_valid  in  1  CPU request valid
- up_req_ready  out  1  request accepted when high together with up_req_valid
- up_req_id  in  ID_W  request ID
- dn_req_valid  out  1  request forwarded to the accelerator
- dn_req_ready  in  1  accelerator can take a request
- dn_resp_valid  in  1  accelerator response strobe; cannot be stalled
- dn_resp_data  in  DATA_W  accelerator response data
- up_resp_valid  out  1  response to CPU valid
- up_resp_ready  in  1  CPU accepts the response
- up_resp_id  out  ID_W  ID of the response
- up_resp_data  out  DATA_W  response data
- outstanding  out  $clog2(DEPTH+1)  current credit use
- resp_err  out  1  sticky error: unexpected response
- timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset: one clock, clk. Reset rst is asynchronous and active-high. While rst is asserted:
  - all FIFO pointers, counters and error flags are cleared;
  - up_resp_valid=0, outstanding=0, resp_err=0, timeout_err=0;
  - up_resp_id and up_resp_data read 0.
  - Asserting rst mid-operation discards all IDs and data; no response is emitted afterwards for those IDs.
- Credit check: not_full = (cnt < DEPTH), where cnt is the registered outstanding count.
  - not_full uses only registered state; there is no combinational path from up_resp_ready to up_req_ready.
- Request path is combinational passthrough:
  - dn_req_valid = up_req_valid & not_full
  - up_req_ready = dn_req_ready & not_full
  - accept = up_req_valid & up_req_ready
- On accept, up_req_id is pushed to the ID FIFO (DEPTH entries).
- On dn_resp_valid, if pending > 0 (pending = IDs issued with no response received yet):
  - dn_resp_data is pushed to the data FIFO (DEPTH entries);
  - pending decrements.
- If dn_resp_valid arrives with pending == 0: data is dropped and resp_err is set. resp_err stays set until reset.
- Credit accounting guarantees the data FIFO never overflows; no overflow check is required.
- Response output:
  - up_resp_valid = data FIFO non-empty.
  - up_resp_id = ID FIFO head; up_resp_data = data FIFO head.
  - Response latency is one cycle: data strobed at cycle N is visible at cycle N+1.
- deliver = up_resp_valid & up_resp_ready. It pops both FIFOs in the same cycle. Outputs stay stable while up_resp_valid=1 and up_resp_ready=0.
- Count updates each cycle: cnt_next = cnt + accept − deliver.
  - Simultaneous accept and deliver leaves cnt unchanged.
  - When cnt == DEPTH, a slot freed by a same-cycle deliver is usable only from the next cycle.
- pending updates each cycle: pending + accept − (dn_resp_valid & pending>0).
  - A response in the same cycle as its own request's accept is not matched, because pending is evaluated before the update.
- outstanding = cnt.
- FIFO pointers use modulo-DEPTH wrap-around, valid for any DEPTH, including non-powers of two.

Optional Feature:
- Macro: CFU_RESP_TRACKER_TIMEOUT_EN.
- When defined, a watchdog counter of $clog2(TIMEOUT_CYCLES+1) bits runs as follows:
  - it increments each cycle while pending > 0;
  - it clears to 0 on any matched dn_resp_valid, or when pending == 0;
  - on reaching TIMEOUT_CYCLES it sets timeout_err, which stays set until reset. The counter saturates at that value.
- When not defined: no counter is built and timeout_err is tied to 0.

Test Plan:
1. Reset, then 3 back-to-back requests with IDs 5, 6, 7 and dn_req_ready=1. Accelerator responds with 0xA, 0xB, 0xC; up_resp_ready=1. Expected: responses (5,0xA), (6,0xB), (7,0xC), each one cycle after its strobe; outstanding returns to 0.
2. DEPTH=4, up_resp_ready=0, 4 requests accepted. Expected: 5th request sees up_req_ready=0 and dn_req_valid=0, outstanding=4. Raise up_resp_ready for one cycle: one delivery, then the 5th request is accepted on the following cycle.
3. Hold up_resp_ready=0 while the accelerator strobes 4 responses. Expected: data FIFO holds all four and up_resp_data stays on the first until ready rises; no resp_err.
4. dn_resp_valid with no request outstanding. Expected: resp_err=1 from the next cycle and stays set; up_resp_valid stays 0.
5. 2 requests outstanding, assert rst mid-sequence, then the accelerator strobes 1 response. Expected: outputs are 0 during reset; after reset the response sets resp_err, and no stale ID appears.
6. With CFU_RESP_TRACKER_TIMEOUT_EN and TIMEOUT_CYCLES=16: issue 1 request and withhold the response. Expected: timeout_err=1 exactly 16 cycles after pending becomes 1. Without the macro, timeout_err stays 0.
